// File: rtl/rvc_dmem_arb_pkg.sv
// Shared types and defaults for the rvc data-memory arbiter.
package rvc_dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_CORE = 2'd1,
    LOCK_EXT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    CORE = 1'b0,
    EXT  = 1'b1
  } master_e;

  localparam int unsigned DEFAULT_MAX_LOCK = 16;

endpackage

// File: rtl/rvc_rr_pick2.sv
// Two-input round-robin picker: one-hot grant, tie goes to the master that was not granted last.
module rvc_rr_pick2
  import rvc_dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_e    last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == CORE) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/rvc_dmem_arb.sv
// Shares the single D_MEM port between the core (master 0) and an external loader (master 1),
// with round-robin arbitration, a bounded lock and steering of the 1-cycle read return.
module rvc_dmem_arb
  import rvc_dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = DEFAULT_MAX_LOCK
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                CoreReq,
  input  logic                CoreWrEn,
  input  logic                CoreLock,
  input  logic [ADDR_W-1:0]   CoreAddr,
  input  logic [DATA_W-1:0]   CoreWrData,
  input  logic [DATA_W/8-1:0] CoreByteEn,
  output logic                CoreGnt,
  output logic                CoreRdValid,
  input  logic                ExtReq,
  input  logic                ExtWrEn,
  input  logic                ExtLock,
  input  logic [ADDR_W-1:0]   ExtAddr,
  input  logic [DATA_W-1:0]   ExtWrData,
  input  logic [DATA_W/8-1:0] ExtByteEn,
  output logic                ExtGnt,
  output logic                ExtRdValid,
  output logic [DATA_W-1:0]   RdData,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWrData,
  output logic [DATA_W/8-1:0] MemByteEn,
  output logic                MemWrEn,
  output logic                MemRdEn,
  input  logic [DATA_W-1:0]   MemRdData,
  output logic                LockTimeout
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_e       state_q, state_d;
  master_e          last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  master_e          rd_owner_q, rd_owner_d;

  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       any_gnt;
  logic       sel_wr;

  rvc_rr_pick2 u_pick (
    .req      ({ExtReq, CoreReq}),
    .last_gnt (last_gnt_q),
    .gnt      (rr_gnt)
  );

  always_comb begin
    gnt          = '0;
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    lock_cnt_d   = lock_cnt_q;
    LockTimeout  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt = rr_gnt;
        if (gnt[0]) begin
          last_gnt_d = CORE;
          if (CoreLock) begin
            state_d    = LOCK_CORE;
            lock_cnt_d = '0;
          end
        end else if (gnt[1]) begin
          last_gnt_d = EXT;
          if (ExtLock) begin
            state_d    = LOCK_EXT;
            lock_cnt_d = '0;
          end
        end
      end
      LOCK_CORE: begin
        gnt        = {1'b0, CoreReq};
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        // Timeout wins over a Lock=1 transfer, but that transfer is still granted.
        if (lock_cnt_q == CNT_LAST) begin
          LockTimeout = 1'b1;
          state_d     = IDLE;
        end else if (CoreReq && !CoreLock) begin
          state_d = IDLE;
        end
      end
      LOCK_EXT: begin
        gnt        = {ExtReq, 1'b0};
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (lock_cnt_q == CNT_LAST) begin
          LockTimeout = 1'b1;
          state_d     = IDLE;
        end else if (ExtReq && !ExtLock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Requests seen while reset is held must not reach the memory.
    if (Rst) begin
      gnt = '0;
    end
  end

  assign CoreGnt = gnt[0];
  assign ExtGnt  = gnt[1];
  assign any_gnt = |gnt;

  always_comb begin
    MemAddr   = '0;
    MemWrData = '0;
    MemByteEn = '0;
    sel_wr    = 1'b0;
    if (gnt[1]) begin
      MemAddr   = ExtAddr;
      MemWrData = ExtWrData;
      MemByteEn = ExtByteEn;
      sel_wr    = ExtWrEn;
    end else if (gnt[0]) begin
      MemAddr   = CoreAddr;
      MemWrData = CoreWrData;
      MemByteEn = CoreByteEn;
      sel_wr    = CoreWrEn;
    end
  end

  assign MemWrEn = any_gnt & sel_wr;
  assign MemRdEn = any_gnt & ~sel_wr;

  always_comb begin
    rd_pend_d  = MemRdEn;
    rd_owner_d = rd_owner_q;
    if (MemRdEn) begin
      rd_owner_d = gnt[1] ? EXT : CORE;
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      last_gnt_q <= EXT;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= CORE;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign CoreRdValid = rd_pend_q && (rd_owner_q == CORE);
  assign ExtRdValid  = rd_pend_q && (rd_owner_q == EXT);
  assign RdData      = MemRdData;

endmodule

// File: tb/tb_rvc_dmem_arb.sv
// Directed self-checking bench for rvc_dmem_arb (instantiated with MAX_LOCK=4).
module tb_rvc_dmem_arb;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              Clock = 1'b0;
  logic              Rst;
  logic              CoreReq, CoreWrEn, CoreLock;
  logic [ADDR_W-1:0] CoreAddr;
  logic [DATA_W-1:0] CoreWrData;
  logic [BE_W-1:0]   CoreByteEn;
  logic              CoreGnt, CoreRdValid;
  logic              ExtReq, ExtWrEn, ExtLock;
  logic [ADDR_W-1:0] ExtAddr;
  logic [DATA_W-1:0] ExtWrData;
  logic [BE_W-1:0]   ExtByteEn;
  logic              ExtGnt, ExtRdValid;
  logic [DATA_W-1:0] RdData;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWrData;
  logic [BE_W-1:0]   MemByteEn;
  logic              MemWrEn, MemRdEn;
  logic [DATA_W-1:0] MemRdData;
  logic              LockTimeout;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 Clock = ~Clock;

  rvc_dmem_arb #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_LOCK (4)
  ) dut (
    .Clock       (Clock),
    .Rst         (Rst),
    .CoreReq     (CoreReq),
    .CoreWrEn    (CoreWrEn),
    .CoreLock    (CoreLock),
    .CoreAddr    (CoreAddr),
    .CoreWrData  (CoreWrData),
    .CoreByteEn  (CoreByteEn),
    .CoreGnt     (CoreGnt),
    .CoreRdValid (CoreRdValid),
    .ExtReq      (ExtReq),
    .ExtWrEn     (ExtWrEn),
    .ExtLock     (ExtLock),
    .ExtAddr     (ExtAddr),
    .ExtWrData   (ExtWrData),
    .ExtByteEn   (ExtByteEn),
    .ExtGnt      (ExtGnt),
    .ExtRdValid  (ExtRdValid),
    .RdData      (RdData),
    .MemAddr     (MemAddr),
    .MemWrData   (MemWrData),
    .MemByteEn   (MemByteEn),
    .MemWrEn     (MemWrEn),
    .MemRdEn     (MemRdEn),
    .MemRdData   (MemRdData),
    .LockTimeout (LockTimeout)
  );

  // Inputs change on the falling edge; checks happen 1 time unit later.
  task automatic clear_inputs();
    CoreReq = 0; CoreWrEn = 0; CoreLock = 0; CoreAddr = '0; CoreWrData = '0; CoreByteEn = '0;
    ExtReq  = 0; ExtWrEn  = 0; ExtLock  = 0; ExtAddr  = '0; ExtWrData  = '0; ExtByteEn  = '0;
    MemRdData = '0;
  endtask

  task automatic idle_step();
    @(negedge Clock);
    clear_inputs();
  endtask

  task automatic test_reset();
    @(negedge Clock);
    clear_inputs();
    Rst = 1;
    CoreReq = 1; ExtReq = 1; CoreAddr = 32'h55; ExtAddr = 32'h66;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, CoreRdValid, ExtRdValid, MemWrEn, MemRdEn, LockTimeout} !== 7'b0) begin
      $display("FAIL reset_ctrl: got %b want 0000000",
               {CoreGnt, ExtGnt, CoreRdValid, ExtRdValid, MemWrEn, MemRdEn, LockTimeout});
    end else pass_cnt++;
    total_cnt++;
    if ({MemAddr, MemWrData, MemByteEn} !== '0) begin
      $display("FAIL reset_mem: got addr=%h wd=%h be=%h want 0", MemAddr, MemWrData, MemByteEn);
    end else pass_cnt++;
    @(negedge Clock);
    clear_inputs();
    Rst = 0;
  endtask

  task automatic test_single_read();
    @(negedge Clock);
    clear_inputs();
    CoreReq = 1; CoreAddr = 32'h100; CoreByteEn = 4'hF;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, MemRdEn, MemWrEn} !== 4'b1010 || MemAddr !== 32'h100) begin
      $display("FAIL single_read_gnt: got gnt=%b%b rd=%b wr=%b addr=%h want 1010 addr=00000100",
               CoreGnt, ExtGnt, MemRdEn, MemWrEn, MemAddr);
    end else pass_cnt++;
    @(negedge Clock);
    clear_inputs();
    MemRdData = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if ({CoreRdValid, ExtRdValid} !== 2'b10 || RdData !== 32'hDEADBEEF) begin
      $display("FAIL single_read_ret: got val=%b%b data=%h want 10 data=deadbeef",
               CoreRdValid, ExtRdValid, RdData);
    end else pass_cnt++;
    total_cnt++;
    if ({MemRdEn, MemWrEn, CoreGnt, ExtGnt} !== 4'b0) begin
      $display("FAIL single_read_quiet: got %b want 0000", {MemRdEn, MemWrEn, CoreGnt, ExtGnt});
    end else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt [4];
    logic [1:0] exp_val;
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    exp_val = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      clear_inputs();
      MemRdData = 32'hA000_0000 + 32'(i);
      if (i < 4) begin
        CoreReq = 1; CoreAddr = 32'h200;
        ExtReq  = 1; ExtAddr  = 32'h300;
      end
      #1;
      if (i < 4) begin
        total_cnt++;
        if ({CoreGnt, ExtGnt} !== exp_gnt[i]) begin
          $display("FAIL contention_gnt[%0d]: got %b want %b", i, {CoreGnt, ExtGnt}, exp_gnt[i]);
        end else pass_cnt++;
        total_cnt++;
        if (MemAddr !== ((exp_gnt[i] == 2'b10) ? 32'h200 : 32'h300) || MemRdEn !== 1'b1) begin
          $display("FAIL contention_mux[%0d]: got addr=%h rd=%b", i, MemAddr, MemRdEn);
        end else pass_cnt++;
      end
      if (i > 0) begin
        total_cnt++;
        if ({CoreRdValid, ExtRdValid} !== exp_val) begin
          $display("FAIL contention_rdval[%0d]: got %b want %b", i, {CoreRdValid, ExtRdValid}, exp_val);
        end else pass_cnt++;
      end
      exp_val = (i < 4) ? exp_gnt[i] : 2'b00;
    end
  endtask

  task automatic test_lock();
    @(negedge Clock);
    clear_inputs();
    CoreReq = 1; CoreWrEn = 1; CoreAddr = 32'h40;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, MemWrEn} !== 3'b101) begin
      $display("FAIL lock_pre: got %b want 101", {CoreGnt, ExtGnt, MemWrEn});
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      clear_inputs();
      CoreReq = 1; CoreAddr = 32'h44;
      ExtReq = 1; ExtWrEn = 1; ExtLock = (i < 3);
      ExtAddr = 32'h500 + 32'(4 * i); ExtWrData = 32'h11 * 32'(i + 1); ExtByteEn = 4'h3;
      #1;
      total_cnt++;
      if ({CoreGnt, ExtGnt, MemWrEn, MemRdEn, LockTimeout} !== 5'b01100) begin
        $display("FAIL lock_gnt[%0d]: got %b want 01100", i, {CoreGnt, ExtGnt, MemWrEn, MemRdEn, LockTimeout});
      end else pass_cnt++;
      total_cnt++;
      if (MemAddr !== 32'h500 + 32'(4 * i) || MemWrData !== 32'h11 * 32'(i + 1) || MemByteEn !== 4'h3) begin
        $display("FAIL lock_mux[%0d]: got addr=%h wd=%h be=%h", i, MemAddr, MemWrData, MemByteEn);
      end else pass_cnt++;
    end
    @(negedge Clock);
    clear_inputs();
    CoreReq = 1; CoreAddr = 32'h48;
    ExtReq = 1; ExtAddr = 32'h600;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, MemRdEn} !== 3'b101 || MemAddr !== 32'h48) begin
      $display("FAIL lock_release: got gnt=%b%b rd=%b addr=%h want 101 addr=00000048",
               CoreGnt, ExtGnt, MemRdEn, MemAddr);
    end else pass_cnt++;
    idle_step();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      clear_inputs();
      CoreReq = 1; CoreWrEn = 1; CoreLock = 1; CoreAddr = 32'h700 + 32'(i);
      ExtReq = (i > 0); ExtAddr = 32'h800;
      #1;
      total_cnt++;
      if (i < 5) begin
        if ({CoreGnt, ExtGnt} !== 2'b10 || LockTimeout !== (i == 4)) begin
          $display("FAIL timeout_lock[%0d]: got gnt=%b%b to=%b want 10 to=%b",
                   i, CoreGnt, ExtGnt, LockTimeout, (i == 4));
        end else pass_cnt++;
      end else begin
        if ({CoreGnt, ExtGnt, LockTimeout, MemRdEn} !== 4'b0101 || MemAddr !== 32'h800) begin
          $display("FAIL timeout_after: got gnt=%b%b to=%b rd=%b addr=%h want 0101 addr=00000800",
                   CoreGnt, ExtGnt, LockTimeout, MemRdEn, MemAddr);
        end else pass_cnt++;
      end
    end
    @(negedge Clock);
    clear_inputs();
    #1;
    total_cnt++;
    if ({ExtRdValid, LockTimeout} !== 2'b10) begin
      $display("FAIL timeout_rdret: got %b want 10", {ExtRdValid, LockTimeout});
    end else pass_cnt++;
  endtask

  task automatic test_idle();
    int unsigned bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      clear_inputs();
      #1;
      if ({CoreGnt, ExtGnt, MemWrEn, MemRdEn, LockTimeout} !== 5'b0 || {MemAddr, MemWrData, MemByteEn} !== '0)
        bad++;
    end
    total_cnt++;
    if (bad != 0) begin
      $display("FAIL idle_outputs: got %0d active cycles want 0", bad);
    end else pass_cnt++;
    @(negedge Clock);
    clear_inputs();
    ExtReq = 1; ExtWrEn = 1; ExtAddr = 32'h900;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, MemWrEn} !== 3'b011) begin
      $display("FAIL idle_then_ext: got %b want 011", {CoreGnt, ExtGnt, MemWrEn});
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    @(negedge Clock);
    clear_inputs();
    ExtReq = 1; ExtAddr = 32'hA00;
    #1;
    total_cnt++;
    if ({ExtGnt, MemRdEn} !== 2'b11) begin
      $display("FAIL rstmid_gnt: got %b want 11", {ExtGnt, MemRdEn});
    end else pass_cnt++;
    @(negedge Clock);
    clear_inputs();
    Rst = 1;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, CoreRdValid, ExtRdValid, MemWrEn, MemRdEn, LockTimeout} !== 7'b0
        || {MemAddr, MemWrData, MemByteEn} !== '0) begin
      $display("FAIL rstmid_outputs: got %b want 0000000",
               {CoreGnt, ExtGnt, CoreRdValid, ExtRdValid, MemWrEn, MemRdEn, LockTimeout});
    end else pass_cnt++;
    @(negedge Clock);
    Rst = 0;
    #1;
    total_cnt++;
    if ({CoreRdValid, ExtRdValid} !== 2'b00) begin
      $display("FAIL rstmid_norv: got %b want 00", {CoreRdValid, ExtRdValid});
    end else pass_cnt++;
    @(negedge Clock);
    clear_inputs();
    CoreReq = 1; ExtReq = 1;
    #1;
    total_cnt++;
    if ({CoreGnt, ExtGnt, CoreRdValid, ExtRdValid} !== 4'b1000) begin
      $display("FAIL rstmid_tie: got %b want 1000", {CoreGnt, ExtGnt, CoreRdValid, ExtRdValid});
    end else pass_cnt++;
    idle_step();
  endtask

  initial begin
    Rst = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    idle_step();
    test_reset();
    test_contention();
    test_lock();
    test_timeout();
    test_idle();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rvc_dmem_arb.md
# rvc_dmem_arb

Two-master arbiter that shares the single data-memory port between the rvc core (master 0) and an external loader/debug master (master 1). It sits between the core's D_MEM interface and the memory wrapper's D_MEM port. It grants at most one transfer per cycle using round-robin, and supports a bounded lock for multi-access sequences. It steers the 1-cycle-latency read data back to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_LOCK, 16, maximum cycles a lock may be held before forced release (≥2)

Ports:
- Clock  in  1  single clock; all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- CoreReq / ExtReq  in  1  request a transfer this cycle
- CoreWrEn / ExtWrEn  in  1  1 = write, 0 = read
- CoreLock / ExtLock  in  1  hold ownership after this transfer
- CoreAddr / ExtAddr  in  ADDR_W  byte address
- CoreWrData / ExtWrData  in  DATA_W  write data
- CoreByteEn / ExtByteEn  in  DATA_W/8  byte enables
- CoreGnt / ExtGnt  out  1  transfer accepted this cycle (combinational)
- CoreRdValid / ExtRdValid  out  1  read data valid for that master (registered)
- RdData  out  DATA_W  MemRdData passed through to both masters
- MemAddr  out  ADDR_W  to memory
- MemWrData  out  DATA_W  to memory
- MemByteEn  out  DATA_W/8  to memory
- MemWrEn  out  1  to memory
- MemRdEn  out  1  to memory
- MemRdData  in  DATA_W  from memory; valid one cycle after MemRdEn
- LockTimeout  out  1  one-cycle pulse on forced lock release

## Operation
- **States:** IDLE, LOCK_CORE, LOCK_EXT. LastGnt register (CORE/EXT). LockCnt counter, width $clog2(MAX_LOCK).
- **Arbitration in IDLE:**
  - Single requester is granted.
  - If both request, the master ≠ LastGnt is granted.
  - LastGnt updates to the granted master on every grant.
- **In LOCK_x:**
  - Only master x can be granted; the other master's Gnt is 0 regardless of its Req.
  - LastGnt is not updated.
- **Lock entry:** in IDLE, a grant to x with xLock=1 moves to LOCK_x and clears LockCnt to 0.
- **Lock behaviour:**
  - In LOCK_x, LockCnt increments every cycle.
  - A grant to x with xLock=0 returns to IDLE.
  - LockCnt==MAX_LOCK-1 forces a return to IDLE and pulses LockTimeout for one cycle, even if x transfers with Lock=1 that cycle. That transfer still completes.
  - A transfer with Lock=1 inside LOCK_x keeps the lock and does not clear LockCnt.
- **Memory mux:** the granted master's Addr, WrData and ByteEn drive the memory outputs.
  - MemWrEn = Gnt & WrEn.
  - MemRdEn = Gnt & ~WrEn.
  - With no grant, all Mem* outputs are 0.
- **Read return:**
  - A read grant sets RdPend=1 and RdOwner=granted master.
  - Next cycle, the owner's RdValid=1. RdPend clears unless a new read is granted that cycle.
  - Back-to-back reads from alternating masters are supported, one per cycle.
- **Writes:** no response; Gnt is the completion.

## Timing
- Gnt is combinational from Req and state, with zero-cycle latency.
- Read data arrives 1 cycle after Gnt.
- Arbitration throughput is 1 transfer/cycle.
- **Reset values:**
  - State IDLE, LastGnt=EXT (core wins the first tie), LockCnt=0, RdPend=0.
  - All Gnt, RdValid, LockTimeout and Mem* outputs are 0.
- **Reset mid-operation:**
  - A pending read is dropped; no RdValid after reset deasserts.
  - A held lock is released.
- **Req deassertion:** a requester may drop Req without a grant; there is no obligation to hold. The arbiter keeps no memory of ungranted requests.
- **Lock owner idle:** if the lock owner does not request, the other master still waits until the lock ends or times out.

## Structure
- Add to param_pkg:
  - typedef enum for arb state (IDLE, LOCK_CORE, LOCK_EXT).
  - typedef enum for master id (CORE=0, EXT=1).
  - Default MAX_LOCK constant.
- One natural sub-module, rvc_rr_pick2: a 2-input round-robin picker taking (Req[1:0], LastGnt) and returning a one-hot grant.
- The rest (FSM, lock counter, mux, read-return register) lives in rvc_dmem_arb.

## Test plan
- **Single read:** core read at Addr 0x100, mem returns 0xDEADBEEF → CoreGnt same cycle, MemRdEn=1, CoreRdValid=1 next cycle with RdData=0xDEADBEEF, ExtRdValid=0.
- **Contention:** both masters request continuously for 4 cycles after reset → grants CORE, EXT, CORE, EXT. Read returns arrive on the matching RdValid one cycle later each.
- **Lock:** Ext writes with ExtLock=1, then 2 more Lock=1 writes, then Lock=0, while Core requests throughout → CoreGnt=0 for all 4 Ext transfers, CoreGnt=1 the cycle after release.
- **Lock timeout:** MAX_LOCK=4; Core locks and keeps Lock=1 → LockTimeout pulses on cycle 4 of the lock, state returns to IDLE, Ext is granted the next cycle.
- **Reset mid-read:** Rst asserted the cycle after a read grant → no RdValid, all outputs 0; the first tie after release goes to Core.
- **Idle:** no Req for 10 cycles → Mem* outputs stay 0 and state stays IDLE.
